// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM backing-memory port arbiter.
// Holds the FSM state enum, grant encoding and the starvation limit default.
`timescale 1ns/1ps
package mem_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        DONE_IF,
        DONE_D
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } gnt_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations fetch has lost in a row.
// Ports: clk, rst_n, inc (lost one), clr (restart), sat (at limit), cnt.
`timescale 1ns/1ps
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);

    assign sat = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between fetch (read-only) and data.
// Ports: IF_* fetch side, D_* data side, MEM_* backing memory; CLK, RESET.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IF_READ,
    input  logic [ADDR_WIDTH-1:0] IF_ADDRESS,
    output logic [DATA_WIDTH-1:0] IF_READDATA,
    output logic                  IF_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    arb_state_e       state;
    arb_state_e       state_n;
    gnt_e             gnt;
    logic             d_req;
    logic             req_cur;
    logic             busy;
    logic             complete;
    logic             accept;
    logic             issued;
    logic             aborted;
    logic             starve_sat;
    logic             starve_inc;
    logic             starve_clr;
    logic [CNT_W-1:0] starve_cnt;

    assign d_req = D_READ | D_WRITE;
    assign busy  = (state == BUSY_IF) || (state == BUSY_D);

    // Request of whichever side currently owns the port.
    assign req_cur = (state == BUSY_IF) ? IF_READ : d_req;

    // The first busy cycle is ignored: memory busywait may not be up yet.
    assign complete = busy && issued && !MEM_BUSYWAIT;

    // A request dropped at any point in the op (flush) discards the result.
    assign accept = complete && req_cur && !aborted;

    assign IF_BUSYWAIT = IF_READ && (state != DONE_IF);
    assign D_BUSYWAIT  = d_req && (state != DONE_D);

    assign starve_inc = (gnt == GNT_D) && IF_READ;
    assign starve_clr = (gnt == GNT_IF) || ((state == IDLE) && !IF_READ);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat),
        .cnt   (starve_cnt)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt     = GNT_NONE;
        unique case (state)
            IDLE: begin
                if (IF_READ && (!d_req || starve_sat)) begin
                    gnt     = GNT_IF;
                    state_n = BUSY_IF;
                end else if (d_req) begin
                    gnt     = GNT_D;
                    state_n = BUSY_D;
                end
            end
            BUSY_IF: begin
                if (complete) state_n = accept ? DONE_IF : IDLE;
            end
            BUSY_D: begin
                if (complete) state_n = accept ? DONE_D : IDLE;
            end
            DONE_IF: state_n = IDLE;
            DONE_D:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            IF_READDATA   <= '0;
            D_READDATA    <= '0;
            issued        <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            if (gnt == GNT_IF) begin
                MEM_READ    <= 1'b1;
                MEM_WRITE   <= 1'b0;
                MEM_ADDRESS <= IF_ADDRESS;
                issued      <= 1'b0;
                aborted     <= 1'b0;
            end else if (gnt == GNT_D) begin
                // Read and write together is taken as a write.
                MEM_READ      <= !D_WRITE;
                MEM_WRITE     <= D_WRITE;
                MEM_ADDRESS   <= D_ADDRESS;
                MEM_WRITEDATA <= D_WRITEDATA;
                issued        <= 1'b0;
                aborted       <= 1'b0;
            end
            if (busy) begin
                issued <= 1'b1;
                if (!req_cur) aborted <= 1'b1;
            end
            if (complete) begin
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
            end
            if (accept && MEM_READ) begin
                if (state == BUSY_IF) IF_READDATA <= MEM_READDATA;
                else                  D_READDATA  <= MEM_READDATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory.
// Expected commands and read data are queued by stimulus, popped by monitors.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_READ;
    logic [31:0] IF_ADDRESS;
    logic [31:0] IF_READDATA;
    logic        IF_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [31:0] D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (2)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IF_READ       (IF_READ),
        .IF_ADDRESS    (IF_ADDRESS),
        .IF_READDATA   (IF_READDATA),
        .IF_BUSYWAIT   (IF_BUSYWAIT),
        .D_READ        (D_READ),
        .D_WRITE       (D_WRITE),
        .D_ADDRESS     (D_ADDRESS),
        .D_WRITEDATA   (D_WRITEDATA),
        .D_READDATA    (D_READDATA),
        .D_BUSYWAIT    (D_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // Backing memory: busy for lat cycles after a command appears.
    logic [31:0] mem [0:1023];
    int          lat  = 3;
    int          mcnt = 0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < lat);
    assign MEM_READDATA = mem[MEM_ADDRESS[11:2]];

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) mcnt <= mcnt + 1;
        else                       mcnt <= 0;
        if (MEM_WRITE && mcnt >= lat)
            mem[MEM_ADDRESS[11:2]] <= MEM_WRITEDATA;
    end

    // Scoreboard queues: {write, read, addr, wdata-or-0}
    logic [65:0] exp_cmd [$];
    logic [31:0] exp_if  [$];
    logic [31:0] exp_d   [$];
    logic        prev_cmd = 1'b0;

    always @(negedge CLK) begin
        logic [65:0] e;
        if ((MEM_READ || MEM_WRITE) && !prev_cmd) begin
            if (exp_cmd.size() == 0) begin
                flag("cmd_unexpected");
            end else begin
                e = exp_cmd.pop_front();
                check("mem_cmd",
                      {MEM_WRITE, MEM_READ, MEM_ADDRESS,
                       MEM_WRITE ? MEM_WRITEDATA : 32'h0}, e);
            end
        end
        prev_cmd <= MEM_READ || MEM_WRITE;
    end

    always @(negedge CLK) begin
        logic [31:0] e;
        if (RESET && IF_READ && !IF_BUSYWAIT) begin
            if (exp_if.size() == 0) begin
                flag("if_done_unexpected");
            end else begin
                e = exp_if.pop_front();
                check("if_rdata", IF_READDATA, e);
            end
        end
    end

    always @(negedge CLK) begin
        logic [31:0] e;
        if (RESET && (D_READ || D_WRITE) && !D_BUSYWAIT) begin
            if (exp_d.size() == 0) begin
                flag("d_done_unexpected");
            end else begin
                e = exp_d.pop_front();
                check("d_rdata", D_READDATA, e);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Fetch requester: holds the request until it sees its DONE.
    task automatic do_if(input logic [31:0] a, input int exp_cyc);
        int cyc = 0;
        bit ok  = 0;
        IF_ADDRESS = a;
        IF_READ    = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (!IF_BUSYWAIT) begin
                ok = 1;
                break;
            end
            cyc++;
        end
        if (!ok) flag("if_timeout");
        else if (exp_cyc >= 0) check("if_latency", cyc, exp_cyc);
        tick();
        IF_READ = 1'b0;
    endtask

    // Data requester: keep=1 chains straight into the next request.
    task automatic do_d(input logic [31:0] a, input logic rd,
                        input logic wr, input logic [31:0] wd,
                        input bit keep, input int exp_cyc);
        int cyc = 0;
        bit ok  = 0;
        D_ADDRESS   = a;
        D_READ      = rd;
        D_WRITE     = wr;
        D_WRITEDATA = wd;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (!D_BUSYWAIT) begin
                ok = 1;
                break;
            end
            cyc++;
        end
        if (!ok) flag("d_timeout");
        else if (exp_cyc >= 0) check("d_latency", cyc, exp_cyc);
        tick();
        if (!keep) begin
            D_READ  = 1'b0;
            D_WRITE = 1'b0;
        end
    endtask

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h040 >> 2] = 32'h0010_0093;
        mem[32'h080 >> 2] = 32'h1234_5678;
        mem[32'h104 >> 2] = 32'hCAFE_0001;
        mem[32'h108 >> 2] = 32'hCAFE_0002;

        RESET       = 1'b0;
        IF_READ     = 1'b0;
        IF_ADDRESS  = 32'h0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDRESS   = 32'h0;
        D_WRITEDATA = 32'h0;

        // Reset state
        #1;
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_mem_addr", MEM_ADDRESS, 0);
        check("rst_if_rdata", IF_READDATA, 0);
        check("rst_d_rdata", D_READDATA, 0);
        check("rst_if_bw_idle", IF_BUSYWAIT, 0);
        IF_READ = 1'b1;
        #1;
        check("rst_if_bw_req", IF_BUSYWAIT, 1);
        IF_READ = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();

        // Single fetch, L=3: DONE at cycle 5
        lat = 3;
        exp_cmd.push_back({RD, 32'h40, 32'h0});
        exp_if.push_back(32'h0010_0093);
        do_if(32'h40, 5);

        // Fetch and store together: store first, fetch after its DONE
        lat = 2;
        exp_cmd.push_back({WR, 32'h100, 32'hDEAD_BEEF});
        exp_cmd.push_back({RD, 32'h40, 32'h0});
        exp_d.push_back(32'h0);
        exp_if.push_back(32'h0010_0093);
        fork
            do_d(32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 4);
            do_if(32'h40, 9);
        join
        check("wr_keeps_d_rdata", D_READDATA, 0);

        // Starvation: limit 2, fetch wins the third arbitration
        lat = 1;
        exp_cmd.push_back({RD, 32'h100, 32'h0});
        exp_cmd.push_back({RD, 32'h104, 32'h0});
        exp_cmd.push_back({RD, 32'h80, 32'h0});
        exp_cmd.push_back({RD, 32'h108, 32'h0});
        exp_d.push_back(32'hDEAD_BEEF);
        exp_d.push_back(32'hCAFE_0001);
        exp_d.push_back(32'hCAFE_0002);
        exp_if.push_back(32'h1234_5678);
        fork
            do_if(32'h80, -1);
            begin
                do_d(32'h100, 1'b1, 1'b0, 32'h0, 1, -1);
                do_d(32'h104, 1'b1, 1'b0, 32'h0, 1, -1);
                do_d(32'h108, 1'b1, 1'b0, 32'h0, 0, -1);
            end
        join
        tick();
        check("starve_cnt_clear", dut.starve_cnt, 0);

        // Flush of an in-flight fetch, L=4
        lat = 4;
        exp_cmd.push_back({RD, 32'h40, 32'h0});
        exp_cmd.push_back({RD, 32'h104, 32'h0});
        exp_d.push_back(32'hCAFE_0001);
        fork
            begin
                IF_ADDRESS = 32'h40;
                IF_READ    = 1'b1;
                tick();
                tick();
                IF_READ = 1'b0;
            end
            begin
                tick();
                do_d(32'h104, 1'b1, 1'b0, 32'h0, 0, 11);
            end
        join
        check("flush_if_rdata", IF_READDATA, 32'h1234_5678);

        // Reset in the middle of a data read
        lat = 3;
        exp_cmd.push_back({RD, 32'h100, 32'h0});
        D_ADDRESS = 32'h100;
        D_READ    = 1'b1;
        tick();
        tick();
        #2;
        check("pre_rst_mem_read", MEM_READ, 1);
        RESET = 1'b0;
        #1;
        check("async_mem_read", MEM_READ, 0);
        check("async_mem_addr", MEM_ADDRESS, 0);
        check("async_mem_wdata", MEM_WRITEDATA, 0);
        check("async_if_rdata", IF_READDATA, 0);
        check("async_d_rdata", D_READDATA, 0);
        check("async_d_bw", D_BUSYWAIT, 1);
        D_READ = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        exp_cmd.push_back({RD, 32'h104, 32'h0});
        exp_d.push_back(32'hCAFE_0001);
        do_d(32'h104, 1'b1, 1'b0, 32'h0, 0, 5);

        // Read and write together acts as a write
        lat = 2;
        exp_cmd.push_back({WR, 32'h200, 32'h5555_AAAA});
        exp_d.push_back(32'hCAFE_0001);
        do_d(32'h200, 1'b1, 1'b1, 32'h5555_AAAA, 0, 4);
        exp_cmd.push_back({RD, 32'h200, 32'h0});
        exp_d.push_back(32'h5555_AAAA);
        do_d(32'h200, 1'b1, 1'b0, 32'h0, 0, 4);

        tick();
        tick();
        check("cmd_q_empty", exp_cmd.size(), 0);
        check("if_q_empty", exp_if.size(), 0);
        check("d_q_empty", exp_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
